// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Receive-side stream between the UART receiver FIFO and its consumer.
// A word moves when valid_o and ready_i are both high on a clock edge.
// The receiver drives the master modport and the consumer drives the slave modport.
//   data_o       head entry data, 0 when the FIFO is empty
//   valid_o      FIFO not empty
//   ready_i      consumer accepts the head entry
//   parity_err_o head entry parity error
//   frame_err_o  head entry framing error
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 parity_err_o;
  logic                 frame_err_o;

  modport master (
    output data_o, valid_o, parity_err_o, frame_err_o,
    input  ready_i
  );

  modport slave (
    input  data_o, valid_o, parity_err_o, frame_err_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receiver with a first-word-fall-through receive FIFO.
// The receiver has configurable data width, parity and stop bits.
// Each stored entry carries the data word and its parity and framing error flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is decided by a 2-of-3 vote
// over the samples at counts mid-1, mid and mid+1. Without the macro, one sample
// is taken at mid.
// Ports:
//   clk_i     system clock
//   nreset_i  asynchronous active-low reset
//   rx_i      asynchronous serial line, idle high
//   stream    uart_rx_fifo_if master: data_o/valid_o/ready_i/parity_err_o/frame_err_o
//   overrun_o one-cycle pulse when a completed frame is dropped because the FIFO is full
//   level_o   current FIFO occupancy
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 10416,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic                          rx_i,
  uart_rx_fifo_if.master                stream,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int CW  = $clog2(CLK_PER_BIT);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int MID = CLK_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_POS = MID + 1;
`else
  localparam int START_POS = MID;
`endif
  localparam logic [CW-1:0] START_CNT = CW'(START_POS);
  localparam logic [CW-1:0] BIT_CNT   = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STORE
  } state_t;

  state_t               state;
  logic                 sync1, sync2, primed, armed;
  logic                 sample_bit;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err;
  logic                 bit_tick;

  logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          count;
  logic                 valid, full, pop, push, store;
  logic [DATA_BITS+1:0] head;

  // primed blocks arming on the first edge after reset, when sync1 still holds
  // its reset value rather than a real sample of the line.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      primed <= 1'b0;
    end else begin
      sync1  <= rx_i;
      sync2  <= sync1;
      primed <= 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist0, hist1;

  // Keeps the two previous synchronized samples so a bit decision at count n
  // can vote over counts n-2, n-1 and n.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hist0 <= 1'b1;
      hist1 <= 1'b1;
    end else begin
      hist0 <= sync2;
      hist1 <= hist0;
    end
  end

  assign sample_bit = (hist1 & hist0) | (hist1 & sync2) | (hist0 & sync2);
`else
  assign sample_bit = sync2;
`endif

  assign bit_tick = (cnt == BIT_CNT);

  // Receive FSM. A start is accepted only while armed, i.e. once the line has
  // been seen high since reset or since a frame that ended with a low stop bit.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (primed && sync1 && sync2)
        armed <= 1'b1;
      else if (state == S_STORE && frm_err)
        armed <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (armed && !sync2) state <= S_START;
        end
        S_START: begin
          if (cnt == START_CNT) begin
            cnt <= '0;
            if (sample_bit) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              par_err  <= 1'b0;
              frm_err  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            shreg   <= {sample_bit, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == LAST_DATA)
              state <= (PARITY == 0) ? S_STOP : S_PARITY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_err <= sample_bit != ((PARITY == 2) ? ^shreg : ~^shreg);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            cnt      <= '0;
            stop_idx <= ~stop_idx;
            if (!sample_bit) frm_err <= 1'b1;
            if (stop_idx == LAST_STOP) state <= S_STORE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STORE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts the new frame when the head is popped in the same cycle.
  assign store     = (state == S_STORE);
  assign valid     = (count != '0);
  assign full      = (count == FULL_LVL);
  assign pop       = valid && stream.ready_i;
  assign push      = store && (!full || pop);
  assign overrun_o = store && full && !pop;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= {frm_err, par_err, shreg};
  end

  assign head                = mem[rptr];
  assign stream.valid_o      = valid;
  assign stream.data_o       = valid ? head[DATA_BITS-1:0] : '0;
  assign stream.parity_err_o = valid & head[DATA_BITS];
  assign stream.frame_err_o  = valid & head[DATA_BITS+1];
  assign level_o             = count;

endmodule
